// File: rtl/gb_cpu_ir_ctrl_if.sv
// rtl/gb_cpu_ir_ctrl_if.sv - fetch/interrupt/decoder bus of the instruction register front end
interface gb_cpu_ir_ctrl_if #(
  parameter int NUM_IRQ = 5
);
  logic [7:0]         mem_rdata;
  logic               fetch_valid;
  logic               cb_next;
  logic               ei_req;
  logic               di_req;
  logic               reti_req;
  logic               halt_req;
  logic [NUM_IRQ-1:0] int_enable;
  logic [NUM_IRQ-1:0] int_flag;
  logic [7:0]         opcode;
  logic               cb_prefix;
  logic               isr_cmd;
  logic [7:0]         isr_vector;
  logic [NUM_IRQ-1:0] if_clear;
  logic               ime;
  logic               halted;
  logic               pc_hold;

  // Sequencer / interrupt-register side driving the controller
  modport master (
    output mem_rdata, fetch_valid, cb_next, ei_req, di_req, reti_req, halt_req,
    output int_enable, int_flag,
    input  opcode, cb_prefix, isr_cmd, isr_vector, if_clear, ime, halted, pc_hold
  );

  // Controller side
  modport slave (
    input  mem_rdata, fetch_valid, cb_next, ei_req, di_req, reti_req, halt_req,
    input  int_enable, int_flag,
    output opcode, cb_prefix, isr_cmd, isr_vector, if_clear, ime, halted, pc_hold
  );
endinterface

// File: rtl/gb_cpu_ir_ctrl.sv
// rtl/gb_cpu_ir_ctrl.sv - instruction register, CB prefix tracking, IME/EI delay, HALT and IRQ dispatch
module gb_cpu_ir_ctrl #(
  parameter logic [7:0] RESET_OPCODE = 8'h00,
  parameter int         NUM_IRQ      = 5
) (
  input logic              clk,
  input logic              rst_n,
  gb_cpu_ir_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_ISR  = 2'd2;

  logic [1:0]         state;
  logic [7:0]         opcode_q;
  logic               cb_prefix_q;
  logic               isr_cmd_q;
  logic [7:0]         isr_vector_q;
  logic [NUM_IRQ-1:0] if_clear_q;
  logic               ime_q;
  logic               ei_delay;
  logic               halted_q;
  logic               pc_hold_q;

  logic [NUM_IRQ-1:0] irq_req;
  logic               pending;
  logic               ime_eff;
  logic [7:0]         idx;
  logic [7:0]         vector_nxt;
  logic [NUM_IRQ-1:0] clear_nxt;

  // Arbitration: lowest set bit of IE&IF wins; vector and IF-clear mask derived from it
  always_comb begin
    irq_req = bus.int_enable & bus.int_flag;
    pending = |irq_req;
    ime_eff = ime_q | ei_delay;
    idx     = 8'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) idx = 8'(i);
    end
    vector_nxt = 8'h40 + (idx << 3);
    clear_nxt  = {{(NUM_IRQ-1){1'b0}}, 1'b1} << idx;
  end

  // Boundary sequencing; DI/RETI act every cycle and DI has the final say on IME
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      opcode_q     <= RESET_OPCODE;
      cb_prefix_q  <= 1'b0;
      isr_cmd_q    <= 1'b0;
      isr_vector_q <= 8'h00;
      if_clear_q   <= '0;
      ime_q        <= 1'b0;
      ei_delay     <= 1'b0;
      halted_q     <= 1'b0;
      pc_hold_q    <= 1'b0;
    end else begin
      if_clear_q <= '0;
      if (bus.fetch_valid) begin
        // EI promotion happens one boundary after EI itself
        if (ei_delay) begin
          ime_q    <= 1'b1;
          ei_delay <= 1'b0;
        end
        if (bus.ei_req) ei_delay <= 1'b1;

        if (bus.cb_next) begin
          // Prefix and its second byte are indivisible: no dispatch here
          state       <= ST_RUN;
          opcode_q    <= bus.mem_rdata;
          cb_prefix_q <= 1'b1;
        end else if (ime_eff && pending) begin
          state        <= ST_ISR;
          isr_cmd_q    <= 1'b1;
          isr_vector_q <= vector_nxt;
          if_clear_q   <= clear_nxt;
          ime_q        <= 1'b0;
          ei_delay     <= 1'b0;
          halted_q     <= 1'b0;
          pc_hold_q    <= 1'b1;
        end else if (bus.halt_req || (state == ST_HALT && !pending)) begin
          state       <= ST_HALT;
          isr_cmd_q   <= 1'b0;
          halted_q    <= 1'b1;
          pc_hold_q   <= 1'b1;
          opcode_q    <= RESET_OPCODE;
          cb_prefix_q <= 1'b0;
        end else begin
          // Normal fetch, HALT wake without dispatch, or end of an ISR
          state       <= ST_RUN;
          opcode_q    <= bus.mem_rdata;
          cb_prefix_q <= 1'b0;
          isr_cmd_q   <= 1'b0;
          halted_q    <= 1'b0;
          pc_hold_q   <= 1'b0;
        end
      end
      if (bus.reti_req) ime_q <= 1'b1;
      if (bus.di_req) begin
        ime_q    <= 1'b0;
        ei_delay <= 1'b0;
      end
    end
  end

  assign bus.opcode     = opcode_q;
  assign bus.cb_prefix  = cb_prefix_q;
  assign bus.isr_cmd    = isr_cmd_q;
  assign bus.isr_vector = isr_vector_q;
  assign bus.if_clear   = if_clear_q;
  assign bus.ime        = ime_q;
  assign bus.halted     = halted_q;
  assign bus.pc_hold    = pc_hold_q;

endmodule
